// File: rtl/quickq_cmd_frontend_if.sv
// rtl/quickq_cmd_frontend_if.sv - host/controller signal bundle for the QuickQ command front-end
//
// Purpose: groups the host command/response handshake, the control-FSM strobe
//          and completion signals, and the occupancy status into one bundle.
// Modports:
//   slave  - the front-end itself (takes commands, drives strobes/responses)
//   master - the environment (host plus QuickQ control FSM)
// Signals:
//   s_valid/s_ready/s_op/s_data   host command channel (s_op 0=enq, 1=deq)
//   r_valid/r_ready/r_data/r_err  host response channel
//   q_enq/q_deq/q_din             strobes and enqueue value to control FSM
//   q_done/q_dout                 completion pulse and dequeued value
//   occupancy/q_full/q_empty      QuickQ fill level
//   fault                         sticky timeout indicator
interface quickq_cmd_frontend_if #(
  parameter int DATA_W     = 32,
  parameter int Q_CAPACITY = 64
);
  localparam int OCC_W = $clog2(Q_CAPACITY + 1);

  logic              s_valid;
  logic              s_ready;
  logic              s_op;
  logic [DATA_W-1:0] s_data;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic              q_enq;
  logic              q_deq;
  logic [DATA_W-1:0] q_din;
  logic              q_done;
  logic [DATA_W-1:0] q_dout;
  logic [OCC_W-1:0]  occupancy;
  logic              q_full;
  logic              q_empty;
  logic              fault;

  modport slave (
    input  s_valid, s_op, s_data, r_ready, q_done, q_dout,
    output s_ready, r_valid, r_data, r_err, q_enq, q_deq, q_din,
           occupancy, q_full, q_empty, fault
  );

  modport master (
    output s_valid, s_op, s_data, r_ready, q_done, q_dout,
    input  s_ready, r_valid, r_data, r_err, q_enq, q_deq, q_din,
           occupancy, q_full, q_empty, fault
  );
endinterface

// File: rtl/quickq_cmd_frontend.sv
// rtl/quickq_cmd_frontend.sv - command FIFO and single-op sequencer in front of the QuickQ control FSM
//
// Purpose: buffers host enqueue/dequeue commands, issues them one at a time to
//          the QuickQ control FSM as one-cycle strobes, waits for completion
//          (with timeout) and returns exactly one response per command.
//          Commands that would overflow/underflow QuickQ are rejected locally.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - quickq_cmd_frontend_if.slave (command, response, strobe, status)
module quickq_cmd_frontend #(
  parameter int DATA_W     = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int Q_CAPACITY = 64,
  parameter int DONE_TMO   = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  quickq_cmd_frontend_if.slave bus
);

  localparam int OCC_W = $clog2(Q_CAPACITY + 1);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int TMO_W = (DONE_TMO > 2) ? $clog2(DONE_TMO) : 1;

  localparam logic [PTR_W:0]   PTR_ONE  = 1;
  localparam logic [OCC_W-1:0] OCC_ONE  = 1;
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(Q_CAPACITY);
  localparam logic [TMO_W-1:0] TMO_ONE  = 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TMO - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO: {op, data} entries; pointers carry one extra wrap bit so
  // full and empty are distinguishable without a separate counter.
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   fifo_mem [CMD_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              head_op;
  logic [DATA_W-1:0] head_data;

  state_t            state_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push       = bus.s_valid && !fifo_full;
  // The head is consumed in every IDLE cycle it exists, whether it is issued
  // or rejected, so the FIFO never stalls behind an illegal command.
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;

  assign {head_op, head_data} = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {bus.s_op, bus.s_data};
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic              op_q;       // 1 = dequeue
  logic              q_enq_q;
  logic              q_deq_q;
  logic [DATA_W-1:0] q_din_q;
  logic              r_valid_q;
  logic [DATA_W-1:0] r_data_q;
  logic              r_err_q;
  logic [OCC_W-1:0]  occ_q;
  logic              fault_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              q_full;
  logic              q_empty;

  assign q_full  = (occ_q == OCC_MAX);
  assign q_empty = (occ_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 1'b0;
      q_enq_q   <= 1'b0;
      q_deq_q   <= 1'b0;
      q_din_q   <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_err_q   <= 1'b0;
      occ_q     <= '0;
      fault_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            op_q <= head_op;
            if (head_op ? q_empty : q_full) begin
              // Illegal against current occupancy: answer without a strobe.
              r_valid_q <= 1'b1;
              r_err_q   <= 1'b1;
              r_data_q  <= '0;
              state_q   <= ST_RESP;
            end else begin
              q_enq_q <= !head_op;
              q_deq_q <= head_op;
              q_din_q <= head_op ? '0 : head_data;
              state_q <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          q_enq_q <= 1'b0;
          q_deq_q <= 1'b0;
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (bus.q_done) begin
            if (op_q) begin
              occ_q    <= occ_q - OCC_ONE;
              r_data_q <= bus.q_dout;
            end else begin
              occ_q    <= occ_q + OCC_ONE;
              r_data_q <= '0;
            end
            r_err_q   <= 1'b0;
            r_valid_q <= 1'b1;
            q_din_q   <= '0;
            state_q   <= ST_RESP;
          end else if (tmo_q == TMO_LAST) begin
            // Controller presumed hung; occupancy is left as it was.
            r_err_q   <= 1'b1;
            r_data_q  <= '0;
            r_valid_q <= 1'b1;
            fault_q   <= 1'b1;
            q_din_q   <= '0;
            state_q   <= ST_RESP;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end

        ST_RESP: begin
          if (bus.r_ready) begin
            r_valid_q <= 1'b0;
            r_err_q   <= 1'b0;
            r_data_q  <= '0;
            state_q   <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ready   = !fifo_full;
  assign bus.r_valid   = r_valid_q;
  assign bus.r_data    = r_data_q;
  assign bus.r_err     = r_err_q;
  assign bus.q_enq     = q_enq_q;
  assign bus.q_deq     = q_deq_q;
  assign bus.q_din     = q_din_q;
  assign bus.occupancy = occ_q;
  assign bus.q_full    = q_full;
  assign bus.q_empty   = q_empty;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_quickq_cmd_frontend.sv
// tb/tb_quickq_cmd_frontend.sv - directed self-checking bench for quickq_cmd_frontend
module tb_quickq_cmd_frontend;

  localparam int DATA_W     = 32;
  localparam int CMD_DEPTH  = 4;
  localparam int Q_CAPACITY = 64;
  localparam int DONE_TMO   = 1024;

  logic clk;
  logic rst_n;

  quickq_cmd_frontend_if #(.DATA_W(DATA_W), .Q_CAPACITY(Q_CAPACITY)) bus ();

  quickq_cmd_frontend #(
    .DATA_W    (DATA_W),
    .CMD_DEPTH (CMD_DEPTH),
    .Q_CAPACITY(Q_CAPACITY),
    .DONE_TMO  (DONE_TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk    = 0;
  int n_pass   = 0;
  int n_strobe = 0;
  int n_served = 0;
  int n_wide   = 0;
  logic last_deq    = 1'b0;
  logic prev_strobe = 1'b0;

  // Strobe monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.q_enq || bus.q_deq) begin
      n_strobe = n_strobe + 1;
      last_deq = bus.q_deq;
      if (prev_strobe) n_wide = n_wide + 1;
    end
    prev_strobe = bus.q_enq || bus.q_deq;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic op, input logic [DATA_W-1:0] data);
    int t = 0;
    bus.s_valid = 1'b1;
    bus.s_op    = op;
    bus.s_data  = data;
    while (!bus.s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_ready) chk("push_to", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_op    = 1'b0;
    bus.s_data  = '0;
  endtask

  task automatic wait_strobe(input string tag, output bit ok);
    int t = 0;
    while (n_strobe <= n_served && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = (n_strobe > n_served);
    if (!ok) chk({tag, "_strobe_to"}, 64'd0, 64'd1);
    else n_served = n_served + 1;
  endtask

  task automatic serve(input string tag, input logic exp_deq, input logic [DATA_W-1:0] exp_din,
                       input logic [DATA_W-1:0] dout, input int dly);
    bit ok;
    wait_strobe(tag, ok);
    if (ok) begin
      chk({tag, "_op"}, last_deq, exp_deq);
      chk({tag, "_din"}, bus.q_din, exp_din);
      repeat (dly) @(negedge clk);
      bus.q_done = 1'b1;
      bus.q_dout = dout;
      @(negedge clk);
      bus.q_done = 1'b0;
      bus.q_dout = '0;
      chk({tag, "_rlat"}, bus.r_valid, 1'b1);
    end
  endtask

  task automatic get_resp(input string tag, input logic [DATA_W-1:0] exp_data,
                          input logic exp_err, input int bound);
    int t = 0;
    while (!bus.r_valid && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (!bus.r_valid) chk({tag, "_resp_to"}, 64'd0, 64'd1);
    else begin
      chk({tag, "_rdata"}, bus.r_data, exp_data);
      chk({tag, "_rerr"}, bus.r_err, exp_err);
      bus.r_ready = 1'b1;
      @(negedge clk);
      bus.r_ready = 1'b0;
      chk({tag, "_rdrop"}, bus.r_valid, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int t;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_op    = 1'b0;
    bus.s_data  = '0;
    bus.r_ready = 1'b0;
    bus.q_done  = 1'b0;
    bus.q_dout  = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_s_ready", bus.s_ready, 1'b1);
    chk("rst_q_empty", bus.q_empty, 1'b1);
    chk("rst_outs", {bus.r_valid, bus.r_err, bus.q_enq, bus.q_deq, bus.q_full, bus.fault}, 6'b0);
    chk("rst_occ", bus.occupancy, 7'd0);
    chk("rst_rdata", bus.r_data, 32'd0);
    chk("rst_qdin", bus.q_din, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Dequeue on empty queue: rejected with no strobe
    push(1'b1, 32'h0);
    get_resp("t2", 32'h0, 1'b1, 20);
    chk("t2_nostrobe", n_strobe, 0);
    chk("t2_occ", bus.occupancy, 7'd0);

    // Two enqueues, q_done three cycles after each strobe
    push(1'b0, 32'h10);
    chk("t1_lat_lo", bus.q_enq, 1'b0);
    @(negedge clk);
    chk("t1_lat_hi", bus.q_enq, 1'b1);
    serve("t1a", 1'b0, 32'h10, 32'h0, 2);
    get_resp("t1a", 32'h0, 1'b0, 20);
    chk("t1_qdin_idle", bus.q_din, 32'h0);
    push(1'b0, 32'h05);
    serve("t1b", 1'b0, 32'h05, 32'h0, 2);
    get_resp("t1b", 32'h0, 1'b0, 20);
    chk("t1_occ", bus.occupancy, 7'd2);
    chk("t1_single", n_wide, 0);

    // Fill to capacity, reject overflow, then dequeue one
    for (int i = 0; i < Q_CAPACITY - 2; i++) begin
      push(1'b0, 32'h100 + i);
      serve("fill", 1'b0, 32'h100 + i, 32'h0, 1);
      get_resp("fill", 32'h0, 1'b0, 20);
    end
    chk("t3_occ_full", bus.occupancy, 7'd64);
    chk("t3_qfull", bus.q_full, 1'b1);
    push(1'b0, 32'hAA);
    get_resp("t3rej", 32'h0, 1'b1, 20);
    chk("t3_nostrobe", n_strobe, n_served);
    push(1'b1, 32'h0);
    serve("t3deq", 1'b1, 32'h0, 32'h01, 1);
    get_resp("t3deq", 32'h01, 1'b0, 20);
    chk("t3_occ", bus.occupancy, 7'd63);
    chk("t3_qfull_lo", bus.q_full, 1'b0);

    // Five commands with no completion: FIFO fills behind the one in flight
    push(1'b0, 32'h11);
    push(1'b1, 32'h0);
    push(1'b0, 32'h22);
    push(1'b0, 32'h33);
    push(1'b1, 32'h0);
    chk("t4_sready_lo", bus.s_ready, 1'b0);
    serve("t4a", 1'b0, 32'h11, 32'h0, 1);
    get_resp("t4a", 32'h0, 1'b0, 20);
    serve("t4b", 1'b1, 32'h0, 32'h55, 1);
    get_resp("t4b", 32'h55, 1'b0, 20);
    serve("t4c", 1'b0, 32'h22, 32'h0, 1);
    get_resp("t4c", 32'h0, 1'b0, 20);
    get_resp("t4d", 32'h0, 1'b1, 20);
    chk("t4d_nostrobe", n_strobe, n_served);
    serve("t4e", 1'b1, 32'h0, 32'h66, 1);
    get_resp("t4e", 32'h66, 1'b0, 20);
    chk("t4_occ", bus.occupancy, 7'd63);
    chk("t4_sready_hi", bus.s_ready, 1'b1);

    // Timeout: no q_done at all
    push(1'b0, 32'h77);
    wait_strobe("t5", ok);
    t = 0;
    while (!bus.r_valid && t < DONE_TMO + 20) begin
      @(negedge clk);
      t++;
    end
    chk("t5_tmo_cycles", t, DONE_TMO + 1);
    get_resp("t5", 32'h0, 1'b1, 5);
    chk("t5_fault", bus.fault, 1'b1);
    chk("t5_occ", bus.occupancy, 7'd63);
    bus.q_done = 1'b1;
    bus.q_dout = 32'hDEAD;
    @(negedge clk);
    bus.q_done = 1'b0;
    bus.q_dout = '0;
    repeat (3) @(negedge clk);
    chk("t5_late_occ", bus.occupancy, 7'd63);
    chk("t5_late_rvalid", bus.r_valid, 1'b0);
    chk("t5_fault_sticky", bus.fault, 1'b1);

    // Reset during WAIT with a second command buffered
    push(1'b0, 32'h99);
    wait_strobe("t6", ok);
    push(1'b1, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_outs", {bus.r_valid, bus.r_err, bus.q_enq, bus.q_deq, bus.q_full, bus.fault}, 6'b0);
    chk("t6_empty_ready", {bus.q_empty, bus.s_ready}, 2'b11);
    chk("t6_occ", bus.occupancy, 7'd0);
    chk("t6_qdin", bus.q_din, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_nostrobe", n_strobe, n_served);
    chk("t6_noresp", bus.r_valid, 1'b0);
    chk("t6_occ_after", bus.occupancy, 7'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
